// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator bridge.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        MISS   = 2'd3
    } apb_mstate_t;

    localparam logic [31:0] APB_BAD_DATA = 32'hBAD1_BAD1;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decode: window match against BASE_ADDR plus slave index and one-hot select.
module apb_addr_decode #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SEL_LSB    = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          IDX_W      = 2
) (
    input  logic [31-SEL_LSB:0]  addr_hi_i,
    output logic                 hit_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic [NUM_SLAVES-1:0] sel_o
);

    logic             win_match;
    logic             in_range;
    logic [IDX_W-1:0] idx;

    // addr_hi_i carries only PADDR[31:SEL_LSB]; slaves decode the bits below.
    assign idx       = addr_hi_i[IDX_W-1:0];
    assign win_match = (addr_hi_i[31-SEL_LSB:IDX_W] == BASE_ADDR[31:SEL_LSB+IDX_W]);
    assign in_range  = ({{(32-IDX_W){1'b0}}, idx} < 32'(NUM_SLAVES));

    assign hit_o = win_match && in_range;
    assign idx_o = idx;
    assign sel_o = hit_o ? (NUM_SLAVES'(1) << idx) : '0;

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: converts a valid/ready request port into SETUP/ACCESS transfers with
// wait-state handling, decode-miss and timeout error responses.
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int          NUM_SLAVES     = 4,
    parameter int          SEL_LSB        = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    // Request: transferred on a cycle with req_valid && req_ready; payload is
    // captured on that edge and may change freely afterwards.
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [31:0]                PADDR,
    output logic [31:0]                PWDATA,
    output logic                       PWRITE,
    output logic [NUM_SLAVES-1:0]      PSEL,
    output logic                       PENABLE,
    input  logic [NUM_SLAVES-1:0][31:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]      PREADY,
    input  logic [NUM_SLAVES-1:0]      pslverr,
    output logic [1:0]                 dbg_state_o
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    apb_mstate_t state_q, state_d;

    logic [31:0]           paddr_q,    paddr_d;
    logic [31:0]           pwdata_q,   pwdata_d;
    logic                  pwrite_q,   pwrite_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [NUM_SLAVES-1:0] sel_q,      sel_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  accept;
    logic                  access_done;
    logic                  access_expire;

    apb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_LSB    (SEL_LSB),
        .BASE_ADDR  (BASE_ADDR),
        .IDX_W      (IDX_W)
    ) u_decode (
        .addr_hi_i (req_addr[31:SEL_LSB]),
        .hit_o     (dec_hit),
        .idx_o     (dec_idx),
        .sel_o     (dec_sel)
    );

    assign accept        = req_valid && req_ready;
    assign access_done   = (state_q == ACCESS) && PREADY[idx_q];
    // The TIMEOUT_CYCLES-th low-PREADY cycle is the last one tolerated.
    assign access_expire = (state_q == ACCESS) && !PREADY[idx_q] &&
                           (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = dec_hit ? SETUP : MISS;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (access_done || access_expire) state_d = IDLE;
            MISS:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE) && !rst;
        PSEL        = ((state_q == SETUP) || (state_q == ACCESS)) ? sel_q : '0;
        PENABLE     = (state_q == ACCESS);
        dbg_state_o = state_q;
    end

    always_comb begin
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        idx_d       = idx_q;
        sel_d       = sel_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (accept) begin
            paddr_d    = req_addr;
            pwdata_d   = req_wdata;
            pwrite_d   = req_write;
            idx_d      = dec_idx;
            sel_d      = dec_sel;
            wait_cnt_d = '0;
        end

        if ((state_q == ACCESS) && !PREADY[idx_q]) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (access_done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA[idx_q];
            rsp_err_d   = pslverr[idx_q];
        end else if (access_expire || (state_q == MISS)) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = APB_BAD_DATA;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            idx_q       <= '0;
            sel_q       <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// checked against a transaction-level model of decode, wait states and timeout.
module tb_apb_master_bridge;

    localparam int          NS   = 4;
    localparam int          TO   = 16;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] BAD  = 32'hBAD1_BAD1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic [31:0]          PADDR;
    logic [31:0]          PWDATA;
    logic                 PWRITE;
    logic [NS-1:0]        PSEL;
    logic                 PENABLE;
    logic [NS-1:0][31:0]  PRDATA;
    logic [NS-1:0]        PREADY;
    logic [NS-1:0]        pslverr;
    logic [1:0]           dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    apb_master_bridge #(
        .NUM_SLAVES     (NS),
        .SEL_LSB        (12),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PWRITE      (PWRITE),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .pslverr     (pslverr),
        .dbg_state_o (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: the window is every address whose value divided by 16 KiB equals BASE's.
    function automatic bit model_hit(input logic [31:0] a);
        return (a / 32'h4000) == (BASE / 32'h4000);
    endfunction

    function automatic int model_idx(input logic [31:0] a);
        return int'((a / 32'h1000) % NS);
    endfunction

    // Unselected slaves get random garbage; the addressed one gets the scripted values.
    task automatic drive_slaves(input int sel, input logic rdy, input logic [31:0] d, input logic e);
        for (int i = 0; i < NS; i++) begin
            PREADY[i]  = 1'($urandom_range(0, 1));
            PRDATA[i]  = $urandom;
            pslverr[i] = 1'($urandom_range(0, 1));
        end
        if (sel >= 0) begin
            PREADY[sel]  = rdy;
            PRDATA[sel]  = d;
            pslverr[sel] = e;
        end
    endtask

    // Runs one transfer starting at a negedge in IDLE; waits = PREADY-low ACCESS cycles.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int waits, input logic [31:0] sd, input logic se);
        bit   hit     = model_hit(addr);
        int   idx     = model_idx(addr);
        int   exp_acc = (waits >= TO) ? TO : waits + 1;
        int   setup_n = 0;
        int   acc_n   = 0;
        int   lat     = -1;
        logic [32:0] exp;
        logic [32:0] got;

        if (!hit || waits >= TO) exp = {1'b1, BAD};
        else                     exp = {se, wr ? 32'h0 : sd};
        exp_q.push_back(exp);

        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wd;
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_write = 1'($urandom_range(0, 1));

        for (int cyc = 1; cyc <= TO + 8; cyc++) begin
            if (PSEL != 0) begin
                check("psel", PSEL, hit ? (64'd1 << idx) : 64'd0);
                check("paddr", PADDR, addr);
                check("pwrite", PWRITE, wr);
                if (wr) check("pwdata", PWDATA, wd);
                if (PENABLE) acc_n++;
                else         setup_n++;
            end else begin
                check("penable_without_psel", PENABLE, 0);
            end
            if (rsp_valid) begin
                lat = cyc;
                break;
            end
            drive_slaves((hit && PSEL != 0) ? idx : -1, PENABLE && (acc_n > waits), sd, se);
            @(negedge clk);
        end

        got = {rsp_err, rsp_rdata};
        exp = exp_q.pop_front();
        check("rsp_seen", lat >= 0, 1);
        check("rsp_data", got, exp);
        check("rsp_latency", lat, hit ? 2 + exp_acc : 2);
        check("setup_cycles", setup_n, hit ? 1 : 0);
        check("access_cycles", acc_n, hit ? exp_acc : 0);
        @(negedge clk);
        check("rsp_single_pulse", rsp_valid, 0);
        check("rsp_hold", {rsp_err, rsp_rdata}, exp);
    endtask

    // Two requests presented back to back with req_valid never dropping between them.
    task automatic run_back_to_back();
        int          acc_cyc[$];
        int          rsp_cyc[$];
        logic [32:0] rsp_dat[$];
        logic        acc;
        logic [31:0] d1 = $urandom;

        PREADY     = '1;
        pslverr    = 4'b0010;
        for (int i = 0; i < NS; i++) PRDATA[i] = $urandom;
        PRDATA[1]  = d1;
        req_valid  = 1'b1;
        req_addr   = 32'h8000_1008;
        req_write  = 1'b0;
        req_wdata  = $urandom;
        for (int cyc = 0; cyc <= 8; cyc++) begin
            if (rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back({rsp_err, rsp_rdata});
            end
            acc = req_valid && req_ready;
            if (acc) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            if (acc) begin
                if (acc_cyc.size() == 1) begin
                    req_addr  = 32'h8000_3010;
                    req_write = 1'b1;
                    req_wdata = $urandom;
                end else begin
                    req_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        check("b2b_accepts", acc_cyc.size(), 2);
        check("b2b_accept0", acc_cyc.size() > 0 ? acc_cyc[0] : -1, 0);
        check("b2b_accept1", acc_cyc.size() > 1 ? acc_cyc[1] : -1, 3);
        check("b2b_rsps", rsp_cyc.size(), 2);
        check("b2b_rsp0_cycle", rsp_cyc.size() > 0 ? rsp_cyc[0] : -1, 3);
        check("b2b_rsp1_cycle", rsp_cyc.size() > 1 ? rsp_cyc[1] : -1, 6);
        check("b2b_rsp0_slverr", rsp_dat.size() > 0 ? rsp_dat[0] : 33'h0, {1'b1, d1});
        check("b2b_rsp1_write", rsp_dat.size() > 1 ? rsp_dat[1] : 33'h1_FFFF_FFFF, 33'h0);
    endtask

    task automatic run_reset_mid_access();
        PREADY    = '0;
        req_valid = 1'b1;
        req_addr  = 32'h8000_0010;
        req_write = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5 && !PENABLE; i++) @(negedge clk);
        check("rst_reached_access", PENABLE, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_rsp", rsp_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        int          w;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_psel", PSEL, 0);
        check("reset_penable", PENABLE, 0);
        check("reset_pwrite", PWRITE, 0);
        check("reset_paddr", PADDR, 0);
        check("reset_pwdata", PWDATA, 0);
        check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        check("reset_req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h8000_1004, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b0);
        run_txn(32'h8000_2020, 1'b1, 32'hCAFE_F00D, 2, 32'h5555_AAAA, 1'b0);
        run_txn(32'h4000_0000, 1'b0, 32'h0, 0, 32'h1111_2222, 1'b0);
        run_txn(32'h8000_3000, 1'b0, 32'h0, TO + 4, 32'h3333_4444, 1'b0);
        run_txn(32'h8000_3004, 1'b1, 32'h0BAD_0001, TO - 1, 32'h0, 1'b0);
        run_txn(32'h8000_0100, 1'b0, 32'h0, 0, 32'h7777_8888, 1'b1);
        run_txn(32'h8001_1000, 1'b1, 32'h1, 0, 32'h0, 1'b0);
        run_back_to_back();
        run_reset_mid_access();
        run_txn(32'h8000_2008, 1'b0, 32'h0, 1, 32'h9ABC_DEF0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)       a = $urandom;
            else if (r == 2) a = BASE | 32'h0001_0000 | ($urandom & 32'h0000_3FFC);
            else             a = BASE | (32'($urandom_range(0, NS - 1)) << 12) | ($urandom & 32'hFFC);
            r = $urandom_range(0, 19);
            if (r < 14)      w = r % 4;
            else if (r < 17) w = r - 10;
            else             w = TO + r - 17;
            run_txn(a, 1'($urandom_range(0, 1)), $urandom, w, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
